// File: rtl/add_seq_ctrl_pkg.sv
// Shared constants and helpers for the multi-word add/subtract sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package add_seq_ctrl_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of the word index; at least one bit so the register always exists.
    function automatic int idx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/add_seq_ctrl_full_adder_32bit.sv
// Existing 32-bit combinational adder datapath with carry in/out.
// Latency: combinational, zero cycles.
// Backpressure: none; outputs follow inputs continuously.
module full_adder_32bit (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);

    // Full 33-bit sum so the top bit becomes the carry-out.
    assign {c_out, sum} = {1'b0, x} + {1'b0, y} + {32'b0, c_in};

endmodule

// File: rtl/add_seq_ctrl.sv
// Wide add/subtract by time-multiplexing one 32-bit adder, one word per cycle, LSW first.
// Latency: start accepted in cycle 0, done pulses in cycle WORDS+1; one op per WORDS+2 cycles.
// Backpressure: start is only taken in IDLE; starts while busy are dropped, not queued.
module add_seq_ctrl
    import add_seq_ctrl_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      op_sub,
    input  logic [WORDS*WORD_W-1:0]   a,
    input  logic [WORDS*WORD_W-1:0]   b,
    input  logic                      cin,
    output logic                      busy,
    output logic                      done,
    output logic [WORDS*WORD_W-1:0]   result,
    output logic                      cout,
    output logic                      ovf
);

    localparam int W  = WORDS * WORD_W;
    localparam int IW = idx_w(WORDS);

    state_t          state, state_nxt;
    logic [IW-1:0]   idx, idx_nxt;
    logic            carry, carry_nxt;
    logic [W-1:0]    a_reg, a_reg_nxt;
    logic [W-1:0]    b_reg, b_reg_nxt;
    logic [W-1:0]    result_nxt;
    logic            cout_nxt, ovf_nxt;
    logic            busy_nxt, done_nxt;

    logic [WORD_W-1:0] x_word, y_word, sum_word;
    logic              c_out;

    // Pick the current word of each operand; b_reg already holds ~b for subtract.
    assign x_word = a_reg[idx*WORD_W +: WORD_W];
    assign y_word = b_reg[idx*WORD_W +: WORD_W];

    full_adder_32bit u_adder (x_word, y_word, carry, sum_word, c_out);

    // Next-state and datapath updates; everything holds unless the state says otherwise.
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        carry_nxt  = carry;
        a_reg_nxt  = a_reg;
        b_reg_nxt  = b_reg;
        result_nxt = result;
        cout_nxt   = cout;
        ovf_nxt    = ovf;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    // Subtract is a + ~b + ~borrow, so invert b and the borrow-in once here.
                    a_reg_nxt  = a;
                    b_reg_nxt  = op_sub ? ~b : b;
                    carry_nxt  = op_sub ^ cin;
                    result_nxt = '0;
                    idx_nxt    = '0;
                    state_nxt  = ST_RUN;
                end
            end
            ST_RUN: begin
                result_nxt[idx*WORD_W +: WORD_W] = sum_word;
                carry_nxt = c_out;
                if (idx == IW'(WORDS - 1)) begin
                    // Signed overflow: same-sign operands producing an opposite-sign sum.
                    cout_nxt  = c_out;
                    ovf_nxt   = (x_word[WORD_W-1] == y_word[WORD_W-1]) &&
                                (sum_word[WORD_W-1] != x_word[WORD_W-1]);
                    state_nxt = ST_DONE;
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Status flags are decoded from the next state so they come straight out of flops.
        busy_nxt = (state_nxt != ST_IDLE);
        done_nxt = (state_nxt == ST_DONE);
    end

    // State, datapath and registered outputs; reset abandons any operation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            idx    <= '0;
            carry  <= 1'b0;
            a_reg  <= '0;
            b_reg  <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            idx    <= idx_nxt;
            carry  <= carry_nxt;
            a_reg  <= a_reg_nxt;
            b_reg  <= b_reg_nxt;
            result <= result_nxt;
            cout   <= cout_nxt;
            ovf    <= ovf_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl against an integer-arithmetic reference model.
// Latency: checks done arrives in cycle WORDS+1 and lasts one cycle.
// Backpressure: checks starts while busy are dropped and reset abandons an op.
module tb_add_seq_ctrl;

    localparam int WORDS = 4;
    localparam int W     = WORDS * 32;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         op_sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout, ovf;
    logic [W-1:0] result;

    int n_cmp = 0;
    int n_err = 0;

    add_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op_sub (op_sub),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int i = 0; i < WORDS; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // Reference: plain wide arithmetic. Signed overflow means the exact signed
    // result does not fit in W bits; cout is the carry for add and "no borrow" for sub.
    function automatic void model(input logic op, input logic [W-1:0] av, input logic [W-1:0] bv,
                                  input logic ci, output logic [W-1:0] r, output logic co,
                                  output logic ov);
        logic [W+1:0] sa, sb, s;
        logic [W:0]   u;
        sa = {{2{av[W-1]}}, av};
        sb = {{2{bv[W-1]}}, bv};
        if (!op) begin
            s  = sa + sb + (W+2)'(ci);
            u  = {1'b0, av} + {1'b0, bv} + (W+1)'(ci);
            co = u[W];
        end else begin
            s  = sa - sb - (W+2)'(ci);
            u  = {1'b0, av} - {1'b0, bv} - (W+1)'(ci);
            co = ~u[W];
        end
        r  = s[W-1:0];
        ov = (s[W] != s[W-1]);
    endfunction

    // Issues one op from IDLE and waits for done; returns in the done cycle.
    task automatic start_op(input logic op, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic ci, output logic [W-1:0] r, output logic co,
                            output logic ov, output int lat);
        op_sub = op; a = av; b = bv; cin = ci; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        op_sub = 1'($urandom); a = rand_w(); b = rand_w(); cin = 1'($urandom);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            if (done) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        r = result; co = cout; ov = ovf;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({busy, done, cout, ovf} !== 4'b0 || result !== '0) begin
            n_err++;
            $display("FAIL reset_held busy=%b done=%b cout=%b ovf=%b result=%h required all zero",
                     busy, done, cout, ovf, result);
        end
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({busy, done, cout, ovf} !== 4'b0 || result !== '0) begin
            n_err++;
            $display("FAIL reset_idle busy=%b done=%b cout=%b ovf=%b result=%h required all zero",
                     busy, done, cout, ovf, result);
        end
    endtask

    task automatic test_directed();
        logic         t_op[7], t_ci[7], t_co[7], t_ov[7];
        logic [W-1:0] t_a[7], t_b[7], t_r[7];
        logic [W-1:0] r;
        logic         co, ov;
        int           lat;
        t_op[0] = 0; t_a[0] = '0; t_a[0][31:0] = 32'hFFFF_FFFF; t_b[0] = W'(1); t_ci[0] = 0;
        t_r[0] = '0; t_r[0][32] = 1'b1; t_co[0] = 0; t_ov[0] = 0;
        t_op[1] = 0; t_a[1] = '1; t_b[1] = W'(1); t_ci[1] = 0;
        t_r[1] = '0; t_co[1] = 1; t_ov[1] = 0;
        t_op[2] = 1; t_a[2] = W'(5); t_b[2] = W'(7); t_ci[2] = 0;
        t_r[2] = '1; t_r[2][0] = 1'b0; t_co[2] = 0; t_ov[2] = 0;
        t_op[3] = 1; t_a[3] = W'(7); t_b[3] = W'(5); t_ci[3] = 0;
        t_r[3] = W'(2); t_co[3] = 1; t_ov[3] = 0;
        t_op[4] = 0; t_a[4] = '1; t_a[4][W-1] = 1'b0; t_b[4] = W'(1); t_ci[4] = 0;
        t_r[4] = '0; t_r[4][W-1] = 1'b1; t_co[4] = 0; t_ov[4] = 1;
        t_op[5] = 0; t_a[5] = '0; t_b[5] = '0; t_ci[5] = 1;
        t_r[5] = W'(1); t_co[5] = 0; t_ov[5] = 0;
        t_op[6] = 1; t_a[6] = '0; t_b[6] = '0; t_ci[6] = 1;
        t_r[6] = '1; t_co[6] = 0; t_ov[6] = 0;
        for (int i = 0; i < 7; i++) begin
            start_op(t_op[i], t_a[i], t_b[i], t_ci[i], r, co, ov, lat);
            n_cmp++;
            if (lat !== WORDS + 1) begin
                n_err++;
                $display("FAIL directed%0d_latency got %0d required %0d", i, lat, WORDS + 1);
            end
            n_cmp++;
            if (r !== t_r[i] || co !== t_co[i] || ov !== t_ov[i]) begin
                n_err++;
                $display("FAIL directed%0d_result got %h cout=%b ovf=%b required %h cout=%b ovf=%b",
                         i, r, co, ov, t_r[i], t_co[i], t_ov[i]);
            end
            @(posedge clk); #1;
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_err++;
                $display("FAIL directed%0d_done_width done=%b busy=%b required 0 0", i, done, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] av, bv, r, er;
        logic         op, ci, co, ov, eco, eov;
        int           lat;
        for (int i = 0; i < 30; i++) begin
            op = 1'($urandom); ci = 1'($urandom);
            av = rand_w(); bv = rand_w();
            case ($urandom_range(0, 3))
                0: bv = ~av;                  // long carry/borrow chains
                1: begin av[W-1] = 1'b0; bv[W-1] = 1'b0; end
                2: bv = av;
                default: ;
            endcase
            model(op, av, bv, ci, er, eco, eov);
            start_op(op, av, bv, ci, r, co, ov, lat);
            n_cmp++;
            if (lat !== WORDS + 1 || r !== er || co !== eco || ov !== eov) begin
                n_err++;
                $display("FAIL random%0d op=%b lat=%0d got %h cout=%b ovf=%b required %h cout=%b ovf=%b",
                         i, op, lat, r, co, ov, er, eco, eov);
            end
            // Next op starts in the cycle right after DONE: back-to-back throughput.
            @(posedge clk); #1;
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] a1, b1, a3, b3, er1, er3;
        logic         eco1, eov1, eco3, eov3;
        int           n_done;
        a1 = rand_w(); b1 = rand_w(); a3 = rand_w(); b3 = rand_w();
        model(1'b0, a1, b1, 1'b1, er1, eco1, eov1);
        model(1'b1, a3, b3, 1'b0, er3, eco3, eov3);
        op_sub = 1'b0; a = a1; b = b1; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_done = 0;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            if (done && cyc <= 10) n_done++;
            case (cyc)
                2: begin start = 1'b1; op_sub = 1'b1; a = rand_w(); b = rand_w(); end
                3: start = 1'b0;
                5: begin
                    n_cmp++;
                    if (done !== 1'b1 || result !== er1 || cout !== eco1 || ovf !== eov1) begin
                        n_err++;
                        $display("FAIL ignore_first done=%b got %h cout=%b ovf=%b required %h cout=%b ovf=%b",
                                 done, result, cout, ovf, er1, eco1, eov1);
                    end
                    start = 1'b1; op_sub = 1'b0; a = rand_w(); b = rand_w();
                end
                6: begin
                    n_cmp++;
                    if (busy !== 1'b0 || done !== 1'b0 || result !== er1) begin
                        n_err++;
                        $display("FAIL ignore_hold busy=%b done=%b result=%h required 0 0 %h",
                                 busy, done, result, er1);
                    end
                    start = 1'b1; op_sub = 1'b1; a = a3; b = b3; cin = 1'b0;
                end
                7: begin
                    start = 1'b0;
                    n_cmp++;
                    if (busy !== 1'b1) begin
                        n_err++;
                        $display("FAIL accept_after_done busy=%b required 1", busy);
                    end
                end
                11: begin
                    n_cmp++;
                    if (done !== 1'b1 || result !== er3 || cout !== eco3 || ovf !== eov3) begin
                        n_err++;
                        $display("FAIL second_op done=%b got %h cout=%b ovf=%b required 1 %h cout=%b ovf=%b",
                                 done, result, cout, ovf, er3, eco3, eov3);
                    end
                end
                default: ;
            endcase
            @(posedge clk); #1;
        end
        n_cmp++;
        if (n_done !== 1) begin
            n_err++;
            $display("FAIL ignore_done_count got %0d required 1", n_done);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [W-1:0] r;
        logic         co, ov;
        int           lat, n_done;
        op_sub = 1'b0; a = '1; b = '1; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;             // cycle 1, idx 0
        start = 1'b0;
        @(posedge clk); #1;             // cycle 2, idx 1
        @(posedge clk); #1;             // cycle 3, idx 2
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({busy, done, cout, ovf} !== 4'b0 || result !== '0) begin
            n_err++;
            $display("FAIL reset_mid_run busy=%b done=%b cout=%b ovf=%b result=%h required all zero",
                     busy, done, cout, ovf, result);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        n_done = 0;
        for (int c = 0; c < WORDS + 3; c++) begin
            if (done || busy) n_done++;
            @(posedge clk); #1;
        end
        n_cmp++;
        if (n_done !== 0) begin
            n_err++;
            $display("FAIL reset_no_done got %0d busy/done cycles required 0", n_done);
        end
        start_op(1'b0, W'(3), W'(4), 1'b0, r, co, ov, lat);
        n_cmp++;
        if (lat !== WORDS + 1 || r !== W'(7) || co !== 1'b0 || ov !== 1'b0) begin
            n_err++;
            $display("FAIL after_reset_add lat=%0d got %h cout=%b ovf=%b required lat=%0d 7 0 0",
                     lat, r, co, ov, WORDS + 1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
